// File: rtl/tcp_tx_scheduler_if.sv
// rtl/tcp_tx_scheduler_if.sv - producer byte streams and SiTCP transmit-port signals of the TCP TX scheduler
interface tcp_tx_scheduler_if #(
   parameter int NUM_SRC = 4
);
   logic                 tcp_open;
   logic                 tcp_tx_full;
   logic [NUM_SRC-1:0]   src_valid;
   logic [8*NUM_SRC-1:0] src_data;
   logic [NUM_SRC-1:0]   src_last;
   logic [NUM_SRC-1:0]   src_ready;
   logic                 tx_wr;
   logic [7:0]           tx_data;

   modport master (
      output tcp_open, tcp_tx_full, src_valid, src_data, src_last,
      input  src_ready, tx_wr, tx_data
   );

   modport slave (
      input  tcp_open, tcp_tx_full, src_valid, src_data, src_last,
      output src_ready, tx_wr, tx_data
   );
endinterface

// File: rtl/tcp_tx_scheduler.sv
// rtl/tcp_tx_scheduler.sv - burst-level round-robin arbiter for the SiTCP TCP transmit byte port
// Define TCP_TX_SCHED_HDR_EN to prefix every burst with the tag byte HDR_BASE | source index.
module tcp_tx_scheduler #(
   parameter int         NUM_SRC   = 4,
   parameter int         MAX_BURST = 256,
   parameter logic [7:0] HDR_BASE  = 8'hA0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   tcp_tx_scheduler_if.slave bus,
   output logic [2:0]        o_grant_id,
   output logic              o_busy,
   output logic [15:0]       o_abort_cnt
);
   localparam int            CW         = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] C_LAST_CNT = CW'(MAX_BURST - 1);

`ifdef TCP_TX_SCHED_HDR_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_HDR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1} state_t;
`endif

   state_t             r_state;
   state_t             w_state_nxt;
   logic [2:0]         r_grant;
   logic [CW-1:0]      r_burst_cnt;
   logic               r_tx_wr;
   logic [7:0]         r_tx_data;
   logic               r_busy;
   logic [15:0]        r_abort_cnt;

   logic               w_found;
   logic [2:0]         w_winner;
   logic               w_gvalid;
   logic               w_glast;
   logic [7:0]         w_gdata;
   logic [7:0]         w_tag;
   logic [NUM_SRC-1:0] w_ready;
   logic               w_select;
   logic               w_xfer;
   logic               w_end;
   logic               w_abort;
   logic               w_hdr_emit;

   assign w_tag = HDR_BASE | {5'b0, r_grant};

   // Round-robin: first valid source strictly after the last grant, wrapping.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_grant;
      for (int k = 1; k <= NUM_SRC; k++) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && bus.src_valid[i] && ((int'(r_grant) + k) % NUM_SRC == i)) begin
               w_found  = 1'b1;
               w_winner = 3'(i);
            end
         end
      end
   end

   always_comb begin
      w_gvalid = 1'b0;
      w_glast  = 1'b0;
      w_gdata  = 8'h00;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (r_grant == 3'(i)) begin
            w_gvalid = bus.src_valid[i];
            w_glast  = bus.src_last[i];
            w_gdata  = bus.src_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = '0;
      w_select    = 1'b0;
      w_xfer      = 1'b0;
      w_end       = 1'b0;
      w_abort     = 1'b0;
      w_hdr_emit  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.tcp_open && !bus.tcp_tx_full && w_found) begin
               w_select = 1'b1;
`ifdef TCP_TX_SCHED_HDR_EN
               w_state_nxt = S_HDR;
`else
               w_state_nxt = S_XFER;
`endif
            end
         end
`ifdef TCP_TX_SCHED_HDR_EN
         S_HDR: begin
            if (!bus.tcp_open) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (!bus.tcp_tx_full) begin
               w_hdr_emit  = 1'b1;
               w_state_nxt = S_XFER;
            end
         end
`endif
         S_XFER: begin
            if (!bus.tcp_open) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               for (int i = 0; i < NUM_SRC; i++) begin
                  w_ready[i] = (r_grant == 3'(i)) && !bus.tcp_tx_full;
               end
               w_xfer = w_gvalid && !bus.tcp_tx_full;
               // last and the MAX_BURST cap on the same byte collapse into one end
               if (w_xfer && (w_glast || r_burst_cnt == C_LAST_CNT)) begin
                  w_end       = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_grant     <= 3'(NUM_SRC - 1);
         r_burst_cnt <= '0;
         r_tx_wr     <= 1'b0;
         r_tx_data   <= 8'h00;
         r_busy      <= 1'b0;
         r_abort_cnt <= 16'h0000;
      end else begin
         if (w_select) r_grant <= w_winner;
         if (w_abort || w_end) r_burst_cnt <= '0;
         else if (w_xfer)      r_burst_cnt <= r_burst_cnt + 1'b1;
         r_tx_wr <= w_xfer | w_hdr_emit;
         if (w_xfer)          r_tx_data <= w_gdata;
         else if (w_hdr_emit) r_tx_data <= w_tag;
         r_busy <= (w_state_nxt != S_IDLE);
         if (w_abort && r_abort_cnt != 16'hFFFF) r_abort_cnt <= r_abort_cnt + 16'd1;
      end
   end

   assign bus.src_ready = w_ready;
   assign bus.tx_wr     = r_tx_wr;
   assign bus.tx_data   = r_tx_data;
   assign o_grant_id    = r_grant;
   assign o_busy        = r_busy;
   assign o_abort_cnt   = r_abort_cnt;
endmodule

// File: tb/tb_tcp_tx_scheduler.sv
// tb/tb_tcp_tx_scheduler.sv - randomized self-checking bench for tcp_tx_scheduler against a burst-level queue model
module tb_tcp_tx_scheduler;
   localparam int         NS = 4;
   localparam int         MB = 8;
   localparam logic [7:0] HB = 8'hA0;
`ifdef TCP_TX_SCHED_HDR_EN
   localparam int HDR_ON = 1;
`else
   localparam int HDR_ON = 0;
`endif

   typedef struct {
      logic [7:0] data;
      logic [2:0] src;
      bit         first;
      int         cyc;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  grant_id;
   logic        busy;
   logic [15:0] abort_cnt;

   always #5 clk = ~clk;

   tcp_tx_scheduler_if #(.NUM_SRC(NS)) bus();

   tcp_tx_scheduler #(.NUM_SRC(NS), .MAX_BURST(MB), .HDR_BASE(HB)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .bus         (bus),
      .o_grant_id  (grant_id),
      .o_busy      (busy),
      .o_abort_cnt (abort_cnt)
   );

   logic [8:0]  src_q [NS][$];
   logic [8:0]  mq    [NS][$];
   wr_t         obs[$];
   wr_t         exp_q[$];
   int          mrr;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          ready_viol, lat_viol;
   bit          tb_open, tb_full;
   int          full_pct, gap_pct;
   logic [NS-1:0] acc, smp_ready;

   function automatic bit anyq();
      for (int s = 0; s < NS; s++) if (src_q[s].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic load(input int s, input logic [7:0] d, input bit last);
      src_q[s].push_back({last, d});
      mq[s].push_back({last, d});
   endtask

   // One clock: drive at negedge, sample ready just before the edge, outputs just after it.
   task automatic tick();
      logic [NS-1:0] v;
      logic [7:0]    acc_byte;
      bit            drv_full;
      drv_full = tb_full || (full_pct > 0 && int'($urandom_range(99)) < full_pct);
      for (int s = 0; s < NS; s++) begin
         v[s] = src_q[s].size() > 0;
         if (v[s] && busy && grant_id == 3'(s) && int'($urandom_range(99)) < gap_pct) v[s] = 1'b0;
         bus.src_data[8*s +: 8] = v[s] ? src_q[s][0][7:0] : 8'($urandom);
         bus.src_last[s]        = v[s] ? src_q[s][0][8] : 1'($urandom);
      end
      bus.src_valid   = v;
      bus.tcp_open    = tb_open;
      bus.tcp_tx_full = drv_full;
      #4;
      smp_ready = bus.src_ready;
      if ($countones(smp_ready) > 1 || (smp_ready != 0 && (!tb_open || drv_full || !busy))) ready_viol++;
      acc      = v & smp_ready;
      acc_byte = 8'h00;
      for (int s = 0; s < NS; s++) if (acc[s]) acc_byte = src_q[s][0][7:0];
      @(posedge clk);
      #1;
      cyc++;
      if (bus.tx_wr === 1'b1 && (drv_full || !tb_open)) lat_viol++;
      if (acc != 0 && (bus.tx_wr !== 1'b1 || bus.tx_data !== acc_byte)) lat_viol++;
      if (acc == 0 && HDR_ON == 0 && bus.tx_wr !== 1'b0) lat_viol++;
      if (bus.tx_wr === 1'b1) obs.push_back('{data: bus.tx_data, src: grant_id, first: 1'b0, cyc: cyc});
      for (int s = 0; s < NS; s++) if (acc[s]) void'(src_q[s].pop_front());
      @(negedge clk);
   endtask

   // Reference: one burst = next nonempty source after the last grant, up to last or MB bytes.
   task automatic model_step();
      int s = 0;
      int n = 0;
      bit found = 1'b0;
      bit done = 1'b0;
      logic [8:0] e;
      for (int k = 1; k <= NS; k++) begin
         if (!found && mq[(mrr + k) % NS].size() > 0) begin
            found = 1'b1;
            s = (mrr + k) % NS;
         end
      end
      if (!found) return;
      mrr = s;
      if (HDR_ON != 0) exp_q.push_back('{data: HB | 8'(s), src: 3'(s), first: 1'b1, cyc: 0});
      while (!done && mq[s].size() > 0) begin
         e = mq[s].pop_front();
         exp_q.push_back('{data: e[7:0], src: 3'(s), first: (n == 0 && HDR_ON == 0), cyc: 0});
         n++;
         if (e[8] || n == MB) done = 1'b1;
      end
   endtask

   task automatic model_drain();
      for (int g = 0; g < 1000; g++) model_step();
   endtask

   function automatic int stream_errors();
      int e = 0;
      int n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
      if (obs.size() != exp_q.size()) e++;
      for (int i = 0; i < n; i++) begin
         if (obs[i].data !== exp_q[i].data || obs[i].src !== exp_q[i].src) e++;
         if (exp_q[i].first && i > 0 && obs[i].cyc - obs[i-1].cyc < 2) e++;
      end
      return e;
   endfunction

   task automatic run_drain(input int max_ticks, output bit timed_out);
      int n = 0;
      while ((anyq() || busy) && n < max_ticks) begin
         tick();
         n++;
      end
      repeat (3) tick();
      timed_out = (n >= max_ticks);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tb_open = 1'b1; tb_full = 1'b0; full_pct = 0; gap_pct = 0;
      bus.tcp_open = 1'b1; bus.tcp_tx_full = 1'b0;
      bus.src_valid = '1; bus.src_data = '0; bus.src_last = '0;
      for (int s = 0; s < NS; s++) begin src_q[s].delete(); mq[s].delete(); end
      obs.delete(); exp_q.delete();
      mrr = NS - 1; ready_viol = 0; lat_viol = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus.src_valid = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.tcp_open = 1'b1; bus.tcp_tx_full = 1'b0; bus.src_valid = '1;
      #1;
      n_checks++; if (bus.tx_wr !== 1'b0) begin n_fail++; $display("FAIL reset_tx_wr: got %b want 0", bus.tx_wr); end
      n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
      n_checks++; if (grant_id !== 3'(NS - 1)) begin n_fail++; $display("FAIL reset_grant: got %0d want %0d", grant_id, NS - 1); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (abort_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_abort_cnt: got %0d want 0", abort_cnt); end
      n_checks++; if (bus.src_ready !== '0) begin n_fail++; $display("FAIL reset_src_ready: got %b want 0", bus.src_ready); end
   endtask

   task automatic test_single_burst();
      bit to;
      int e;
      do_reset();
      for (int j = 1; j <= 4; j++) load(0, 8'(j), j == 4);
      model_drain();
      run_drain(200, to);
      e = stream_errors();
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b want 0", to); end
      n_checks++; if (e !== 0) begin n_fail++; $display("FAIL single_stream: got %0d errors want 0", e); end
      n_checks++; if (obs.size() !== 4 + HDR_ON) begin n_fail++; $display("FAIL single_count: got %0d want %0d", obs.size(), 4 + HDR_ON); end
      else begin
         n_checks++;
         if (obs[3 + HDR_ON].cyc - obs[HDR_ON].cyc !== 3) begin
            n_fail++; $display("FAIL single_consecutive: got span %0d want 3", obs[3 + HDR_ON].cyc - obs[HDR_ON].cyc);
         end
      end
      n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL single_grant: got %0d want 0", grant_id); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
      n_checks++; if (lat_viol !== 0 || ready_viol !== 0) begin n_fail++; $display("FAIL single_timing: got lat %0d ready %0d want 0 0", lat_viol, ready_viol); end
   endtask

   task automatic test_round_robin();
      bit to;
      int e;
      int want[6] = '{0, 1, 2, 0, 1, 2};
      do_reset();
      for (int b = 0; b < 2; b++)
         for (int s = 0; s < 3; s++) begin
            load(s, 8'($urandom), 1'b0);
            load(s, 8'($urandom), 1'b1);
         end
      model_drain();
      run_drain(300, to);
      e = stream_errors();
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rr_timeout: got %b want 0", to); end
      n_checks++; if (e !== 0) begin n_fail++; $display("FAIL rr_stream: got %0d errors want 0", e); end
      if (obs.size() == 6 * (2 + HDR_ON)) begin
         for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs[i * (2 + HDR_ON)].src !== 3'(want[i])) begin
               n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, obs[i * (2 + HDR_ON)].src, want[i]);
            end
         end
      end else begin
         n_checks++; n_fail++; $display("FAIL rr_count: got %0d want %0d", obs.size(), 6 * (2 + HDR_ON));
      end
   endtask

   task automatic test_max_burst();
      int e;
      int n = 0;
      int c3 = 0;
      do_reset();
      for (int j = 0; j < 20; j++) load(3, 8'(j + 8'h10), 1'b0);
      model_step();
      tick(); tick();
      load(1, 8'hB1, 1'b0);
      load(1, 8'hB2, 1'b1);
      model_drain();
      while (anyq() && n < 400) begin tick(); n++; end
      repeat (4) tick();
      e = stream_errors();
      for (int i = 0; i < obs.size(); i++) if (obs[i].src == 3'd3 && (HDR_ON == 0 || obs[i].data[7:4] != 4'hA)) c3++;
      n_checks++; if (n >= 400) begin n_fail++; $display("FAIL maxb_timeout: got %0d ticks want < 400", n); end
      n_checks++; if (e !== 0) begin n_fail++; $display("FAIL maxb_stream: got %0d errors want 0", e); end
      n_checks++; if (c3 !== 20) begin n_fail++; $display("FAIL maxb_src3_bytes: got %0d want 20", c3); end
      n_checks++; if (busy !== 1'b1 || grant_id !== 3'd3) begin n_fail++; $display("FAIL maxb_hold: got busy %b grant %0d want 1 3", busy, grant_id); end
   endtask

   task automatic test_full_stall();
      bit to;
      int e;
      int acc_n = 0;
      int stall = -1;
      int wr_stall = 0;
      int rdy_bad = 0;
      int n = 0;
      do_reset();
      for (int j = 1; j <= 6; j++) load(0, 8'($urandom), j == 6);
      model_drain();
      while ((anyq() || busy) && n < 200) begin
         if (stall == 0) tb_full = 1'b0;
         tick();
         n++;
         if (stall > 0) begin
            if (smp_ready != 0) rdy_bad++;
            if (bus.tx_wr === 1'b1) wr_stall++;
            stall--;
         end
         if (acc[0]) begin
            acc_n++;
            if (acc_n == 3) begin tb_full = 1'b1; stall = 5; end
         end
      end
      run_drain(50, to);
      e = stream_errors();
      n_checks++; if (n >= 200 || to) begin n_fail++; $display("FAIL stall_timeout: got %0d ticks want < 200", n); end
      n_checks++; if (rdy_bad !== 0) begin n_fail++; $display("FAIL stall_ready: got %0d ready cycles want 0", rdy_bad); end
      n_checks++; if (wr_stall > 1) begin n_fail++; $display("FAIL stall_writes: got %0d want <= 1", wr_stall); end
      n_checks++; if (e !== 0) begin n_fail++; $display("FAIL stall_stream: got %0d errors want 0", e); end
      n_checks++; if (obs.size() !== 6 + HDR_ON) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", obs.size(), 6 + HDR_ON); end
   endtask

   task automatic test_open_abort();
      bit to;
      int e;
      int acc_n = 0;
      int n = 0;
      int bad = 0;
      logic [7:0] b2;
      do_reset();
      for (int j = 1; j <= 10; j++) load(0, 8'($urandom), j == 10);
      for (int j = 1; j <= 3; j++) load(1, 8'($urandom), j == 3);
      b2 = src_q[0][1][7:0];
      while (acc_n < 2 && n < 50) begin
         tick();
         n++;
         if (acc[0]) acc_n++;
      end
      n_checks++; if (obs.size() !== 2 + HDR_ON || obs[obs.size() - 1].data !== b2) begin
         n_fail++; $display("FAIL abort_pre_bytes: got %0d writes want %0d ending in %h", obs.size(), 2 + HDR_ON, b2);
      end
      tb_open = 1'b0;
      tick();
      n_checks++; if (bus.tx_wr !== 1'b0) begin n_fail++; $display("FAIL abort_tx_wr: got %b want 0", bus.tx_wr); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_checks++; if (abort_cnt !== 16'd1) begin n_fail++; $display("FAIL abort_cnt: got %0d want 1", abort_cnt); end
      obs.delete();
      repeat (5) begin
         tick();
         if (busy !== 1'b0 || bus.tx_wr !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL abort_closed_grant: got %0d active cycles want 0", bad); end
      for (int s = 0; s < NS; s++) mq[s] = src_q[s];
      exp_q.delete();
      mrr = 0;
      model_drain();
      tb_open = 1'b1;
      run_drain(300, to);
      e = stream_errors();
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL abort_timeout: got %b want 0", to); end
      n_checks++; if (e !== 0) begin n_fail++; $display("FAIL abort_stream: got %0d errors want 0", e); end
      n_checks++; if (obs.size() == 0 || obs[0].src !== 3'd1) begin n_fail++; $display("FAIL abort_regrant: got %0d writes want first grant 1", obs.size()); end
      n_checks++; if (abort_cnt !== 16'd1) begin n_fail++; $display("FAIL abort_cnt_hold: got %0d want 1", abort_cnt); end
   endtask

`ifdef TCP_TX_SCHED_HDR_EN
   task automatic test_header();
      bit to;
      do_reset();
      load(2, 8'h55, 1'b0);
      load(2, 8'h66, 1'b1);
      run_drain(100, to);
      n_checks++; if (obs.size() !== 3) begin n_fail++; $display("FAIL hdr_count: got %0d want 3", obs.size()); end
      else begin
         n_checks++; if (obs[0].data !== 8'hA2) begin n_fail++; $display("FAIL hdr_tag: got %h want a2", obs[0].data); end
         n_checks++; if (obs[1].data !== 8'h55 || obs[2].data !== 8'h66) begin n_fail++; $display("FAIL hdr_data: got %h %h want 55 66", obs[1].data, obs[2].data); end
      end
   endtask
`endif

   task automatic test_random();
      bit to;
      int e;
      int len;
      for (int r = 0; r < 3; r++) begin
         do_reset();
         full_pct = 20;
         gap_pct  = 30;
         for (int s = 0; s < NS; s++) begin
            if ($urandom_range(3) == 0) continue;
            for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
               len = int'($urandom_range(1, 12));
               for (int j = 0; j < len; j++) load(s, 8'($urandom), j == len - 1);
            end
         end
         model_drain();
         run_drain(3000, to);
         e = stream_errors();
         n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout: got %b want 0", r, to); end
         n_checks++; if (e !== 0) begin n_fail++; $display("FAIL rand%0d_stream: got %0d errors want 0 (%0d vs %0d writes)", r, e, obs.size(), exp_q.size()); end
         n_checks++; if (lat_viol !== 0) begin n_fail++; $display("FAIL rand%0d_latency: got %0d violations want 0", r, lat_viol); end
         n_checks++; if (ready_viol !== 0) begin n_fail++; $display("FAIL rand%0d_ready: got %0d violations want 0", r, ready_viol); end
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_max_burst();
      test_full_stall();
      test_open_abort();
`ifdef TCP_TX_SCHED_HDR_EN
      test_header();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/tcp_tx_scheduler.md
Name: tcp_tx_scheduler

Overview:
Burst-level round-robin scheduler that shares the single SiTCP TCP transmit byte port between NUM_SRC byte-stream producers, such as the Transport generator and the RX loopback FIFO. It sits between the producers and the SiTCP TCP_TX_WR/TCP_TX_DATA/TCP_TX_FULL interface in the CLK_200M domain. A grant is held for one burst at a time, so bytes from different sources never interleave. Bursts are capped at MAX_BURST bytes so that no source can starve the others.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
MAX_BURST, 256, maximum bytes per grant (1..4096)
HDR_BASE, 8'hA0, tag base for the optional header byte; tag = HDR_BASE | src index

Ports:
clk  in  1  system clock (CLK_200M)
rst  in  1  asynchronous reset, active-high
tcp_open  in  1  TCP_OPEN_ACK from SiTCP; 0 = no connection
tcp_tx_full  in  1  TCP_TX_FULL almost-full flag from SiTCP
src_valid  in  NUM_SRC  per-source byte valid
src_data  in  8*NUM_SRC  per-source byte; source i uses bits [8i+7:8i]
src_last  in  NUM_SRC  per-source end-of-burst marker, qualified by valid
src_ready  out  NUM_SRC  per-source accept, combinational
tx_wr  out  1  to TCP_TX_WR, registered
tx_data  out  8  to TCP_TX_DATA, registered
grant_id  out  3  index of current/last granted source, registered
busy  out  1  1 while not in IDLE
abort_cnt  out  16  saturating count of bursts cut by connection loss

Behaviour:
- Reset values: tx_wr=0, tx_data=8'h00, grant_id=NUM_SRC-1 (so source 0 has first priority), busy=0, abort_cnt=0, state=IDLE, burst_cnt=0.
- States: IDLE, HDR (only with the optional feature), XFER.
- IDLE:
  - Selection happens when tcp_open=1, tcp_tx_full=0 and any src_valid=1.
  - The winner is the first valid source scanning from grant_id+1 upward, modulo NUM_SRC.
  - grant_id is registered to the winner and the next state is HDR or XFER.
  - src_ready is all zeros in IDLE.
- XFER:
  - src_ready[g] = tcp_open & ~tcp_tx_full; all other ready bits are 0.
  - A byte transfers when src_valid[g] & src_ready[g]. The next cycle has tx_wr=1 and tx_data=that byte, giving 1-cycle latency; otherwise tx_wr=0.
  - burst_cnt increments on each transfer.
  - The burst ends on a transfer with src_last[g]=1, or on the transfer that makes burst_cnt==MAX_BURST. Either way: go to IDLE, burst_cnt clears.
  - Both ending conditions on the same byte count as a single end.
- Re-arbitration: the earliest next grant is the cycle after returning to IDLE, so there is a minimum 1-cycle bubble between bursts. Round-robin resumes from the source after grant_id.
- tcp_tx_full=1 mid-burst:
  - src_ready drops in the same cycle and there are no transfers.
  - State, grant and count are held, and the burst resumes when the flag clears.
  - Bytes already registered (one at most) are still written; SiTCP's almost-full margin absorbs this.
- tcp_open falls mid-burst (HDR or XFER):
  - src_ready drops immediately and state goes to IDLE.
  - burst_cnt clears; abort_cnt increments, saturating at 16'hFFFF.
  - The byte registered in that cycle is suppressed: tx_wr=0 on the next cycle.
  - Source framing is the producer's responsibility, since producers are reset from ~TCP_OPEN_ACK.
- src_valid deasserting mid-burst: the grant is held with no timeout; only last, MAX_BURST or connection loss releases it.
- Single requester: it is re-granted after each burst with the 1-cycle bubble.
- busy = (state != IDLE), registered.
- burst_cnt width = clog2(MAX_BURST+1).

Optional Feature:
TCP_TX_SCHED_HDR_EN
- Defined:
  - After a grant, the HDR state emits a single tag byte, HDR_BASE | grant_id, before the source's data.
  - The tag is emitted when tcp_open=1 and tcp_tx_full=0, otherwise HDR waits. It then moves to XFER.
  - src_ready is 0 in HDR, and the tag does not count toward MAX_BURST.
- Undefined: the HDR state and its logic are absent; IDLE goes directly to XFER, and the output stream is raw concatenated bursts.

Test Plan:
- Reset, then source 0 sends 4 bytes 01,02,03,04 with last on 04 (tcp_open=1, full=0) -> tx_wr high 4 consecutive cycles with those bytes, each one cycle after acceptance; grant_id=0; busy falls after 04.
- Sources 0, 1 and 2 all continuously valid with 2-byte bursts -> grant order 0,1,2,0,1,2; no byte interleaving; 1-cycle gap between bursts.
- MAX_BURST=8, source 3 streams 20 bytes with no last and source 1 idle -> bursts of 8, 8 and 4 bytes, with a re-grant to 3 each time; when source 1 is valid during the first burst, order is 3,1,3.
- tcp_tx_full asserted for 5 cycles after byte 3 of a 6-byte burst -> src_ready=0 for those 5 cycles, at most 1 tx_wr during the stall, bytes 4..6 follow in order, total 6 writes.
- tcp_open dropped after byte 2 of a 10-byte burst -> the next cycle has tx_wr=0, state IDLE and abort_cnt=1; no grant is issued while tcp_open=0; after reopening, a new grant goes to the next source in round-robin order.
- With TCP_TX_SCHED_HDR_EN and HDR_BASE=A0, source 2 sends bytes 55,66 with last -> tx_data sequence A2,55,66.
